i2s_rx_fmt: RTL and testbench

//  Parametrised I2S/PCM serial receiver, oversampled in the ACLK domain. Recovers stereo

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_edge_sync.sv | 27 ++
 rtl/i2s_rx_fmt.sv | 206 ++++++++++++++++++++
 tb/tb_i2s_rx_fmt.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Format codes and receiver state encoding shared by the I2S receive and transmit blocks.
package i2s_pkg;

    localparam logic [1:0] FMT_I2S = 2'd0;
    localparam logic [1:0] FMT_LJ  = 2'd1;
    localparam logic [1:0] FMT_RJ  = 2'd2;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_e;

    function automatic logic fmt_is_rj(input logic [1:0] fmt);
        return fmt == FMT_RJ;
    endfunction

    // Code 3 is unassigned and falls back to I2S framing.
    function automatic logic fmt_is_i2s(input logic [1:0] fmt);
        return !((fmt == FMT_LJ) || (fmt == FMT_RJ));
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with rise/fall detect across the last two stages.
module i2s_edge_sync #(
    parameter int STAGES = 3
) (
    input  logic ACLK,
    input  logic ARST,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sr[STAGES-1];
    assign rise     = sr[STAGES-2] & ~sr[STAGES-1];
    assign fall     = ~sr[STAGES-2] & sr[STAGES-1];

endmodule

// File: rtl/i2s_rx_fmt.sv
// Oversampled I2S / left-justified / right-justified stereo receiver with slot-length
// checking, lock detection and a valid/ready sample-pair output with overrun flag.
module i2s_rx_fmt
    import i2s_pkg::*;
#(
    parameter int   DATA_W      = 24,
    parameter int   CNT_W       = 7,
    parameter int   SYNC_STAGES = 3,
    parameter logic LEFT_LVL    = 1'b0
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              BCLK,
    input  logic              LRCLK,
    input  logic              DIN,
    input  logic [1:0]        FMT,
    output logic [DATA_W-1:0] DOUT_L,
    output logic [DATA_W-1:0] DOUT_R,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [CNT_W-1:0]  SLOT_LEN,
    output logic              LOCKED,
    output logic              FRAME_ERR,
    output logic              OVERRUN,
    input  logic              OVR_CLR
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic bclk_level, bclk_rise, bclk_fall;
    logic lr_s, lr_rise, lr_fall;
    logic din_s;
    logic [SYNC_STAGES-1:0] din_sr;
    logic sync_unused;

    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .ACLK     (ACLK),
        .ARST     (ARST),
        .async_in (BCLK),
        .sync_out (bclk_level),
        .rise     (bclk_rise),
        .fall     (bclk_fall)
    );

    i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
        .ACLK     (ACLK),
        .ARST     (ARST),
        .async_in (LRCLK),
        .sync_out (lr_s),
        .rise     (lr_rise),
        .fall     (lr_fall)
    );

    assign sync_unused = ^{bclk_level, bclk_fall, lr_rise, lr_fall};

    // Same depth as the BCLK/LRCLK chains so all three stay aligned.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            din_sr <= '0;
        end else begin
            din_sr <= {din_sr[SYNC_STAGES-2:0], DIN};
        end
    end

    assign din_s = din_sr[SYNC_STAGES-1];

    i2s_state_e        state;
    logic [1:0]        fmt_q;
    logic              lr_d;
    logic              frame_prev;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] left_q;
    logic              good_seen;
    logic [CNT_W-1:0]  good_len;

    logic [1:0]        eff_fmt;
    logic [1:0]        slot_fmt;
    logic              lr_f;
    logic              boundary;
    logic              left_start;
    logic              sat_err;
    logic              len_ok;
    logic              emit;
    logic [31:0]       bit_idx;
    logic [DATA_W-1:0] shreg_next;

    // While hunting there is no latched format yet, so framing follows the live FMT pins.
    always_comb begin
        eff_fmt    = (state == ST_HUNT) ? FMT : fmt_q;
        lr_f       = fmt_is_i2s(eff_fmt) ? lr_d : lr_s;
        boundary   = (lr_f != frame_prev);
        left_start = boundary && (lr_f == LEFT_LVL);
        slot_fmt   = left_start ? FMT : fmt_q;
        sat_err    = bclk_rise && !boundary && (cnt == CNT_MAX) && (state != ST_HUNT);
        len_ok     = (cnt == SLOT_LEN);
        emit       = bclk_rise && boundary && (state == ST_RIGHT) && len_ok;
        bit_idx    = boundary ? 32'd0 : 32'(cnt);
    end

    // The bit on a boundary rise is the first bit of the new slot.
    always_comb begin
        shreg_next = boundary ? '0 : shreg;
        if (fmt_is_rj(slot_fmt)) begin
            shreg_next = {shreg_next[DATA_W-2:0], din_s};
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (bit_idx == 32'(DATA_W - 1 - i)) begin
                    shreg_next[i] = din_s;
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state      <= ST_HUNT;
            fmt_q      <= FMT_I2S;
            lr_d       <= 1'b0;
            frame_prev <= 1'b0;
            cnt        <= '0;
            shreg      <= '0;
            left_q     <= '0;
            SLOT_LEN   <= '0;
            good_seen  <= 1'b0;
            good_len   <= '0;
            LOCKED     <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            if (bclk_rise) begin
                lr_d       <= lr_s;
                frame_prev <= lr_f;
                shreg      <= shreg_next;
                if (boundary) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (left_start) begin
                    fmt_q <= FMT;
                end
                if (sat_err) begin
                    state     <= ST_HUNT;
                    FRAME_ERR <= 1'b1;
                    LOCKED    <= 1'b0;
                    good_seen <= 1'b0;
                end else if (boundary) begin
                    case (state)
                        ST_HUNT: begin
                            if (left_start) begin
                                state <= ST_LEFT;
                            end
                        end
                        ST_LEFT: begin
                            left_q   <= shreg;
                            SLOT_LEN <= cnt;
                            state    <= ST_RIGHT;
                        end
                        ST_RIGHT: begin
                            state <= ST_LEFT;
                            if (len_ok) begin
                                good_seen <= 1'b1;
                                good_len  <= SLOT_LEN;
                                if (good_seen && (good_len == SLOT_LEN)) begin
                                    LOCKED <= 1'b1;
                                end
                            end else begin
                                FRAME_ERR <= 1'b1;
                                LOCKED    <= 1'b0;
                                good_seen <= 1'b0;
                            end
                        end
                        default: state <= ST_HUNT;
                    endcase
                end
            end
        end
    end

    // A held pair always wins over a new one; the new pair is only taken if the slot frees this cycle.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            DOUT_L     <= '0;
            DOUT_R     <= '0;
            DOUT_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            if (emit) begin
                if (!DOUT_VALID || DOUT_READY) begin
                    DOUT_L     <= left_q;
                    DOUT_R     <= shreg;
                    DOUT_VALID <= 1'b1;
                end
            end else if (DOUT_VALID && DOUT_READY) begin
                DOUT_VALID <= 1'b0;
            end
            if (OVR_CLR) begin
                OVERRUN <= 1'b0;
            end else if (emit && DOUT_VALID && !DOUT_READY) begin
                OVERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_fmt.sv
// Directed bench for i2s_rx_fmt: serial frames driven bit by bit, expected pairs scoreboarded.
module tb_i2s_rx_fmt;

    localparam int DATA_W = 24;
    localparam int CNT_W  = 7;

    logic              ACLK = 1'b0;
    logic              ARST = 1'b1;
    logic              BCLK = 1'b0;
    logic              LRCLK = 1'b0;
    logic              DIN = 1'b0;
    logic [1:0]        FMT = 2'd0;
    logic [DATA_W-1:0] DOUT_L;
    logic [DATA_W-1:0] DOUT_R;
    logic              DOUT_VALID;
    logic              DOUT_READY = 1'b1;
    logic [CNT_W-1:0]  SLOT_LEN;
    logic              LOCKED;
    logic              FRAME_ERR;
    logic              OVERRUN;
    logic              OVR_CLR = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int errPulses  = 0;
    int errBase    = 0;
    logic isI2s    = 1'b0;
    logic i2sPrev  = 1'b0;
    logic [47:0] sbQueue[$];

    i2s_rx_fmt dut (
        .ACLK       (ACLK),
        .ARST       (ARST),
        .BCLK       (BCLK),
        .LRCLK      (LRCLK),
        .DIN        (DIN),
        .FMT        (FMT),
        .DOUT_L     (DOUT_L),
        .DOUT_R     (DOUT_R),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .SLOT_LEN   (SLOT_LEN),
        .LOCKED     (LOCKED),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN),
        .OVR_CLR    (OVR_CLR)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One BCLK period; LRCLK/DIN change on the falling edge. I2S data lags LRCLK by one bit.
    task automatic applyStimulus(input logic lr, input logic d);
        BCLK  = 1'b0;
        LRCLK = lr;
        if (isI2s) begin
            DIN     = i2sPrev;
            i2sPrev = d;
        end else begin
            DIN = d;
        end
        #40;
        BCLK = 1'b1;
        #40;
    endtask

    task automatic sendSlot(input logic lr, input int len, input logic [31:0] word, input int nbits, input logic rj);
        for (int i = 0; i < len; i++) begin
            logic b;
            b = 1'b0;
            if (rj) begin
                if (i >= len - nbits) b = word[len-1-i];
            end else if (i < nbits) begin
                b = word[nbits-1-i];
            end
            applyStimulus(lr, b);
        end
    endtask

    task automatic sendFrame(input int lenL, input int lenR, input logic [31:0] wl, input logic [31:0] wr,
                             input int nbits, input logic rj);
        sendSlot(1'b0, lenL, wl, nbits, rj);
        sendSlot(1'b1, lenR, wr, nbits, rj);
    endtask

    task automatic sendIdle(input logic lr, input int n);
        for (int i = 0; i < n; i++) applyStimulus(lr, 1'b0);
    endtask

    task automatic resetDut();
        ARST    = 1'b1;
        BCLK    = 1'b0;
        LRCLK   = 1'b0;
        DIN     = 1'b0;
        i2sPrev = 1'b0;
        #40;
        ARST = 1'b0;
        #40;
    endtask

    task automatic setReady(input logic r);
        @(posedge ACLK);
        #1;
        DOUT_READY = r;
    endtask

    always @(negedge ACLK) begin
        logic [47:0] exp;
        if (FRAME_ERR) errPulses++;
        if (DOUT_VALID && DOUT_READY) begin
            checkOutput("sb_pending", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                exp = sbQueue.pop_front();
                checkOutput("pair_left", 32'(DOUT_L), 32'(exp[47:24]));
                checkOutput("pair_right", 32'(DOUT_R), 32'(exp[23:0]));
            end
        end
    end

    initial begin
        #100;
        checkOutput("rst_dout_l", 32'(DOUT_L), 32'd0);
        checkOutput("rst_dout_r", 32'(DOUT_R), 32'd0);
        checkOutput("rst_valid", 32'(DOUT_VALID), 32'd0);
        checkOutput("rst_slot_len", 32'(SLOT_LEN), 32'd0);
        checkOutput("rst_locked", 32'(LOCKED), 32'd0);
        checkOutput("rst_frame_err", 32'(FRAME_ERR), 32'd0);
        checkOutput("rst_overrun", 32'(OVERRUN), 32'd0);
        ARST = 1'b0;
        #40;

        $display("[TB] I2S 32-bit slots");
        FMT = 2'd0; isI2s = 1'b1;
        checkOutput("i2s_locked_pre", 32'(LOCKED), 32'd0);
        sendIdle(1'b1, 8);
        sbQueue.push_back({24'h123456, 24'hABCDEF});
        sendFrame(32, 32, 32'h123456, 32'hABCDEF, 24, 1'b0);
        sbQueue.push_back({24'h123456, 24'hABCDEF});
        sendFrame(32, 32, 32'h123456, 32'hABCDEF, 24, 1'b0);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("i2s_locked", 32'(LOCKED), 32'd1);
        checkOutput("i2s_slot_len", 32'(SLOT_LEN), 32'd32);
        checkOutput("i2s_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] LJ 16-bit slots");
        resetDut();
        FMT = 2'd1; isI2s = 1'b0; errBase = errPulses;
        sendIdle(1'b1, 8);
        sbQueue.push_back({24'hA5A500, 24'h5A5A00});
        sendFrame(16, 16, 32'hA5A5, 32'h5A5A, 16, 1'b0);
        sbQueue.push_back({24'hA5A500, 24'h5A5A00});
        sendFrame(16, 16, 32'hA5A5, 32'h5A5A, 16, 1'b0);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("lj_no_err", 32'(errPulses - errBase), 32'd0);
        checkOutput("lj_slot_len", 32'(SLOT_LEN), 32'd16);
        checkOutput("lj_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] RJ 32-bit slots");
        resetDut();
        FMT = 2'd2; isI2s = 1'b0;
        sendIdle(1'b1, 8);
        sbQueue.push_back({24'h800001, 24'h7FFFFE});
        sendFrame(32, 32, 32'h800001, 32'h7FFFFE, 24, 1'b1);
        sbQueue.push_back({24'h800001, 24'h7FFFFE});
        sendFrame(32, 32, 32'h800001, 32'h7FFFFE, 24, 1'b1);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("rj_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] backpressure and overrun");
        resetDut();
        FMT = 2'd1; isI2s = 1'b0;
        setReady(1'b0);
        sendIdle(1'b1, 8);
        sbQueue.push_back({24'h111111, 24'h222222});
        sendFrame(32, 32, 32'h111111, 32'h222222, 24, 1'b0);
        sendFrame(32, 32, 32'h333333, 32'h444444, 24, 1'b0);
        sendFrame(32, 32, 32'h555555, 32'h666666, 24, 1'b0);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("bp_valid_held", 32'(DOUT_VALID), 32'd1);
        checkOutput("bp_left_held", 32'(DOUT_L), 32'h111111);
        checkOutput("bp_right_held", 32'(DOUT_R), 32'h222222);
        checkOutput("bp_overrun", 32'(OVERRUN), 32'd1);
        @(posedge ACLK); #1; OVR_CLR = 1'b1;
        @(posedge ACLK); #1; OVR_CLR = 1'b0;
        @(negedge ACLK);
        checkOutput("bp_overrun_clr", 32'(OVERRUN), 32'd0);
        setReady(1'b1);
        @(negedge ACLK);
        @(negedge ACLK);
        checkOutput("bp_valid_drop", 32'(DOUT_VALID), 32'd0);
        checkOutput("bp_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] slot length mismatch and relock");
        resetDut();
        FMT = 2'd0; isI2s = 1'b1; errBase = errPulses;
        sendIdle(1'b1, 8);
        sbQueue.push_back({24'h0A0B0C, 24'h0D0E0F});
        sendFrame(32, 32, 32'h0A0B0C, 32'h0D0E0F, 24, 1'b0);
        sbQueue.push_back({24'h102030, 24'h405060});
        sendFrame(32, 32, 32'h102030, 32'h405060, 24, 1'b0);
        sendFrame(32, 31, 32'hDEAD00, 32'hBEEF00, 24, 1'b0);
        checkOutput("ferr_locked_before", 32'(LOCKED), 32'd1);
        sbQueue.push_back({24'h700001, 24'h8000FF});
        sendFrame(32, 32, 32'h700001, 32'h8000FF, 24, 1'b0);
        checkOutput("ferr_locked_cleared", 32'(LOCKED), 32'd0);
        checkOutput("ferr_one_pulse", 32'(errPulses - errBase), 32'd1);
        sbQueue.push_back({24'hC0FFEE, 24'h00BEEF});
        sendFrame(32, 32, 32'hC0FFEE, 32'h00BEEF, 24, 1'b0);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("ferr_relocked", 32'(LOCKED), 32'd1);
        checkOutput("ferr_still_one", 32'(errPulses - errBase), 32'd1);
        checkOutput("ferr_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] reset mid-frame then format change");
        resetDut();
        FMT = 2'd1; isI2s = 1'b0;
        sendIdle(1'b1, 8);
        sbQueue.push_back({24'h13579B, 24'h2468AC});
        sendFrame(32, 32, 32'h13579B, 32'h2468AC, 24, 1'b0);
        sendSlot(1'b0, 32, 32'h777777, 24, 1'b0);
        sendSlot(1'b1, 10, 32'h999999, 24, 1'b0);
        ARST = 1'b1;
        #40;
        checkOutput("arst_dout_l", 32'(DOUT_L), 32'd0);
        checkOutput("arst_dout_r", 32'(DOUT_R), 32'd0);
        checkOutput("arst_slot_len", 32'(SLOT_LEN), 32'd0);
        checkOutput("arst_valid", 32'(DOUT_VALID), 32'd0);
        ARST = 1'b0;
        #40;
        sendIdle(1'b1, 10);
        FMT = 2'd0; isI2s = 1'b1; i2sPrev = 1'b0;
        sendIdle(1'b1, 12);
        sbQueue.push_back({24'h0F1E2D, 24'h3C4B5A});
        sendFrame(32, 32, 32'h0F1E2D, 32'h3C4B5A, 24, 1'b0);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("arst_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] slot counter saturation");
        resetDut();
        FMT = 2'd1; isI2s = 1'b0; errBase = errPulses;
        sendIdle(1'b1, 8);
        sendIdle(1'b0, 130);
        #400;
        checkOutput("sat_err_pulse", 32'(errPulses - errBase), 32'd1);
        checkOutput("sat_locked", 32'(LOCKED), 32'd0);
        sendIdle(1'b1, 32);
        sendIdle(1'b0, 4);
        #400;
        checkOutput("sat_no_pair", 32'(DOUT_VALID), 32'd0);
        checkOutput("sat_err_once", 32'(errPulses - errBase), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
